cplx_div_sched: RTL and testbench

- Schedules one shared sequential 32/16 divider (signed dividend, unsigned divisor, 33-cycle run) to complete a complex division.
- Upstream logic has already reduced (a+bj)/(c+dj) to numerators num_re = ac+bd and num_im = bc-ad, plus denominator den = c²+d².
- This block issues two back-to-back divider runs (real, then imaginary), captures both quotients, and reports done/error to the top-level complex divider.

---
 rtl/cplx_div_sched.sv | 130 +++++++++++++
 tb/tb_cplx_div_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cplx_div_sched.sv
// Sequencer for one shared 32/16 divider: runs the real then the imaginary
// quotient of a complex division and reports the pair with done/err.
module cplx_div_sched #(
   parameter int DW      = 32,
   parameter int VW      = 16,
   parameter int TIMEOUT = 40
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] num_re,
   input  logic [DW-1:0] num_im,
   input  logic [VW-1:0] den,
   output logic          ready,
   output logic          div_run,
   output logic [DW-1:0] div_dividend,
   output logic [VW-1:0] div_divisor,
   input  logic          div_stop,
   input  logic [DW-1:0] div_quotient,
   output logic [DW-1:0] q_re,
   output logic [DW-1:0] q_im,
   output logic          done,
   output logic          err
);

   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
   localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
   localparam logic [DW-1:0]  SAT_POS = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0]  SAT_NEG = {1'b1, {(DW-1){1'b0}}};

   // DONE is the one-cycle result strobe between the last working state and IDLE
   typedef enum logic [2:0] {
      IDLE, RUN_RE, WAIT_RE, CAP_RE, WAIT_IM, CAP_IM, ZERO, DONE
   } state_t;

   state_t         state, state_nxt;
   logic [DW-1:0]  im_r;
   logic [WDW-1:0] wdog;
   logic           waiting;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      div_run   = 1'b0;
      done      = 1'b0;
      waiting   = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = (den == '0) ? ZERO : RUN_RE;
         end
         RUN_RE: begin
            div_run   = 1'b1;
            state_nxt = WAIT_RE;
         end
         WAIT_RE: begin
            waiting = 1'b1;
            if (div_stop)              state_nxt = CAP_RE;
            else if (wdog == WD_LAST)  state_nxt = DONE;
         end
         CAP_RE: begin
            div_run   = 1'b1;
            state_nxt = WAIT_IM;
         end
         WAIT_IM: begin
            waiting = 1'b1;
            if (div_stop)              state_nxt = CAP_IM;
            else if (wdog == WD_LAST)  state_nxt = DONE;
         end
         CAP_IM:  state_nxt = DONE;
         ZERO:    state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         im_r         <= '0;
         div_dividend <= '0;
         div_divisor  <= '0;
         q_re         <= '0;
         q_im         <= '0;
         err          <= 1'b0;
         wdog         <= '0;
      end else begin
         if (!waiting)            wdog <= '0;
         else if (wdog != WD_MAX) wdog <= wdog + 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  div_dividend <= num_re;
                  im_r         <= num_im;
                  div_divisor  <= den;
                  err          <= 1'b0;
               end
            end
            WAIT_RE, WAIT_IM: begin
               if (div_stop) begin
                  if (state == WAIT_RE) div_dividend <= im_r;
               end else if (wdog == WD_LAST) begin
                  q_re <= '0;
                  q_im <= '0;
                  err  <= 1'b1;
               end
            end
            CAP_RE: q_re <= div_quotient;
            CAP_IM: q_im <= div_quotient;
            ZERO: begin
               // dividend register still holds the real numerator here
               q_re <= div_dividend[DW-1] ? SAT_NEG : SAT_POS;
               q_im <= im_r[DW-1]         ? SAT_NEG : SAT_POS;
               err  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cplx_div_sched.sv
// Randomised self-checking bench for cplx_div_sched with a behavioural
// stand-in for the shared divider and a plain-arithmetic reference model.
module tb_cplx_div_sched;

   localparam int DW      = 32;
   localparam int VW      = 16;
   localparam int TIMEOUT = 40;
   localparam int DIV_CYC = 33;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] num_re = '0;
   logic [DW-1:0] num_im = '0;
   logic [VW-1:0] den = '0;
   logic          ready, div_run, div_stop, done, err;
   logic [DW-1:0] div_dividend, div_quotient, q_re, q_im;
   logic [VW-1:0] div_divisor;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   cplx_div_sched #(.DW(DW), .VW(VW), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .start(start),
      .num_re(num_re), .num_im(num_im), .den(den),
      .ready(ready), .div_run(div_run),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_stop(div_stop), .div_quotient(div_quotient),
      .q_re(q_re), .q_im(q_im), .done(done), .err(err)
   );

   // Divider stand-in: 33-cycle run, stop flag in the last cycle, no reset.
   int unsigned   div_cnt = 0;
   logic          hang = 1'b0;
   logic [DW-1:0] div_q_m = '0;

   always @(posedge clock) begin
      if (div_run) begin
         div_cnt <= DIV_CYC;
         if (div_divisor != '0)
            div_q_m <= DW'(longint'($signed(div_dividend)) / longint'(div_divisor));
      end else if (div_cnt != 0) begin
         div_cnt <= div_cnt - 1;
      end
   end
   assign div_stop     = (div_cnt == 1) && !hang;
   assign div_quotient = div_q_m;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] n, input logic [VW-1:0] d);
      longint q;
      if (d == '0) return n[DW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      q = longint'($signed(n)) / longint'(d);
      return q[DW-1:0];
   endfunction

   task automatic run_op(input logic [DW-1:0] re, input logic [DW-1:0] im,
                         input logic [VW-1:0] dv, input bit hang_en, input bit busy);
      int runs, done_idx, exp_lat, exp_runs;
      logic [DW-1:0] exp_re, exp_im;
      logic exp_err;
      hang = hang_en;
      for (int k = 0; k < 100 && !ready; k++) tick();
      check_eq("ready_pre", 64'(ready), 64'd1);
      num_re = re; num_im = im; den = dv; start = 1'b1;
      tick();
      start = 1'b0;
      num_re = $urandom; num_im = $urandom; den = VW'($urandom);

      if (dv == '0) begin
         exp_lat = 1; exp_runs = 0; exp_err = 1'b1;
         exp_re = ref_q(re, dv); exp_im = ref_q(im, dv);
      end else if (hang_en) begin
         exp_lat = 1 + TIMEOUT; exp_runs = 1; exp_err = 1'b1;
         exp_re = '0; exp_im = '0;
      end else begin
         exp_lat = 2 * (1 + DIV_CYC) + 1; exp_runs = 2; exp_err = 1'b0;
         exp_re = ref_q(re, dv); exp_im = ref_q(im, dv);
      end

      runs = 0; done_idx = -1;
      for (int i = 0; i < 200; i++) begin
         if (div_run) begin
            if (runs == 0) begin
               check_eq("run1_idx", 64'(i), 64'd0);
               check_eq("run1_dividend", 64'(div_dividend), 64'(re));
               check_eq("run1_divisor", 64'(div_divisor), 64'(dv));
            end else begin
               check_eq("run2_idx", 64'(i), 64'(DIV_CYC + 1));
               check_eq("run2_dividend", 64'(div_dividend), 64'(im));
               check_eq("run2_divisor", 64'(div_divisor), 64'(dv));
            end
            runs++;
         end
         if (done) begin
            done_idx = i;
            break;
         end
         if (busy && (i == 10 || i == 40)) begin
            start = 1'b1;
            num_re = $urandom; num_im = $urandom; den = VW'($urandom);
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check_eq("done_latency", 64'(done_idx), 64'(exp_lat));
      check_eq("run_count", 64'(runs), 64'(exp_runs));
      check_eq("q_re", 64'(q_re), 64'(exp_re));
      check_eq("q_im", 64'(q_im), 64'(exp_im));
      check_eq("err", 64'(err), 64'(exp_err));
      check_eq("ready_at_done", 64'(ready), 64'd0);
      tick();
      check_eq("ready_after_done", 64'(ready), 64'd1);
      check_eq("done_one_cycle", 64'(done), 64'd0);
      hang = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation bound exceeded");
      $fatal(1);
   end

   initial begin
      int dones;
      logic [VW-1:0] rd;
      repeat (3) tick();
      check_eq("rst_ready", 64'(ready), 64'd1);
      check_eq("rst_div_run", 64'(div_run), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_err", 64'(err), 64'd0);
      check_eq("rst_q_re", 64'(q_re), 64'd0);
      check_eq("rst_q_im", 64'(q_im), 64'd0);
      check_eq("rst_dividend", 64'(div_dividend), 64'd0);
      reset = 1'b1;
      tick();

      run_op(32'd100, -32'sd50, 16'd7, 1'b0, 1'b0);
      run_op(-32'sd5, 32'd9, 16'd0, 1'b0, 1'b0);
      run_op($urandom, $urandom, VW'($urandom_range(1, 65535)), 1'b0, 1'b1);
      run_op($urandom, $urandom, VW'($urandom_range(1, 65535)), 1'b0, 1'b0);
      run_op($urandom, $urandom, VW'($urandom_range(1, 65535)), 1'b1, 1'b0);

      // async reset in the middle of the real run
      num_re = 32'd1000; num_im = 32'd2000; den = 16'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      #2 reset = 1'b0;
      #1;
      check_eq("arst_ready", 64'(ready), 64'd1);
      check_eq("arst_div_run", 64'(div_run), 64'd0);
      check_eq("arst_done", 64'(done), 64'd0);
      check_eq("arst_q_re", 64'(q_re), 64'd0);
      tick();
      reset = 1'b1;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         if (done) dones++;
         tick();
      end
      check_eq("arst_no_done", 64'(dones), 64'd0);
      check_eq("arst_idle_ready", 64'(ready), 64'd1);
      run_op(32'd1000, 32'd2000, 16'd3, 1'b0, 1'b0);

      run_op(32'h8000_0000, 32'h7FFF_FFFF, 16'hFFFF, 1'b0, 1'b0);

      for (int n = 0; n < 10; n++) begin
         rd = ($urandom_range(0, 3) == 0) ? '0 : VW'($urandom_range(1, 65535));
         if ($urandom_range(0, 1) == 1) rd = rd & 16'h00FF;
         run_op($urandom, $urandom, rd, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
